// File: rtl/psk_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psk_tx_frame_ctrl
// Brief    : PSK transmit frame sequencer (preamble / payload / guard).
// Revision : 1.0 - initial release
// ============================================================================
module psk_tx_frame_ctrl #(
  parameter int SPS       = 8,
  parameter int PRE_LEN   = 16,
  parameter int PAY_LEN   = 64,
  parameter int GUARD_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cfg_use_q,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic sym_bit,
  output logic sym_strobe,
  output logic tx_en,
  output logic strm_sel_q,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int MAX_LEN_A = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
  localparam int MAX_LEN   = (MAX_LEN_A > GUARD_LEN) ? MAX_LEN_A : GUARD_LEN;
  localparam int SAMP_W    = $clog2(SPS);
  localparam int SYM_W     = $clog2((MAX_LEN > 1) ? MAX_LEN : 2);

  localparam logic [SAMP_W-1:0] c_samp_last  = SAMP_W'(SPS - 1);
  localparam logic [SAMP_W-1:0] c_samp_one   = SAMP_W'(1);
  localparam logic [SYM_W-1:0]  c_sym_one    = SYM_W'(1);
  localparam logic [SYM_W-1:0]  c_pre_last   = SYM_W'(PRE_LEN - 1);
  localparam logic [SYM_W-1:0]  c_pay_last   = SYM_W'(PAY_LEN - 1);
  localparam logic [SYM_W-1:0]  c_guard_last = SYM_W'(GUARD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_GUARD    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SAMP_W-1:0] r_samp;
  logic [SYM_W-1:0]  r_sym;
  logic [SYM_W-1:0]  w_len_last;
  logic              w_wrap;
  logic              w_last;
  logic              w_accept;
  logic              r_sym_bit;
  logic              r_tx_en;
  logic              r_busy;
  logic              r_done;
  logic              r_strm_sel_q;
  logic              r_underrun;

  assign w_wrap   = (r_samp == c_samp_last);
  assign w_last   = w_wrap && (r_sym == w_len_last);
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_len_last  = '0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_len_last = c_pre_last;
        if (w_last) w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_len_last = c_pay_last;
        if (w_last) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        w_len_last = c_guard_last;
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A payload bit is pulled on the last sample ahead of every payload symbol.
  always_comb begin
    bit_ready = 1'b0;
    if (w_wrap) begin
      if (r_state == S_PREAMBLE && r_sym == c_pre_last) bit_ready = 1'b1;
      if (r_state == S_PAYLOAD  && r_sym != c_pay_last) bit_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_samp  <= '0;
      r_sym   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || r_state == S_IDLE) begin
        r_samp <= '0;
        r_sym  <= '0;
      end else if (w_wrap) begin
        r_samp <= '0;
        r_sym  <= r_sym + c_sym_one;
      end else begin
        r_samp <= r_samp + c_samp_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_bit    <= 1'b0;
      r_tx_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_strm_sel_q <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_tx_en <= (w_state_nxt == S_PREAMBLE) || (w_state_nxt == S_PAYLOAD);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_GUARD) && w_last;

      // Preamble symbol k+1 carries ~(k+1)[0], which equals k[0].
      if (w_accept)
        r_sym_bit <= 1'b1;
      else if (bit_ready)
        r_sym_bit <= bit_valid & bit_in;
      else if (r_state == S_PREAMBLE && w_wrap)
        r_sym_bit <= r_sym[0];
      else if (r_state == S_PAYLOAD && w_last)
        r_sym_bit <= 1'b0;

      if (w_accept) begin
        r_strm_sel_q <= cfg_use_q;
        r_underrun   <= 1'b0;
      end else if (bit_ready && !bit_valid) begin
        r_underrun   <= 1'b1;
      end
    end
  end

  assign sym_bit    = r_sym_bit;
  assign sym_strobe = (r_samp == '0) &&
                      ((r_state == S_PREAMBLE) || (r_state == S_PAYLOAD));
  assign tx_en      = r_tx_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign strm_sel_q = r_strm_sel_q;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_psk_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psk_tx_frame_ctrl
// Brief    : Directed self-checking bench for psk_tx_frame_ctrl (SPS=4, 4/8/2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_psk_tx_frame_ctrl;

  localparam int SPS       = 4;
  localparam int PRE_LEN   = 4;
  localparam int PAY_LEN   = 8;
  localparam int GUARD_LEN = 2;

  logic clk = 1'b0;
  logic rst, start, cfg_use_q, bit_in, bit_valid;
  logic bit_ready, sym_bit, sym_strobe, tx_en, strm_sel_q, busy, done, underrun;

  int n_chk    = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_ready  = 0;

  psk_tx_frame_ctrl #(
    .SPS(SPS), .PRE_LEN(PRE_LEN), .PAY_LEN(PAY_LEN), .GUARD_LEN(GUARD_LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_use_q(cfg_use_q),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_bit(sym_bit), .sym_strobe(sym_strobe), .tx_en(tx_en),
    .strm_sel_q(strm_sel_q), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_ready"},  bit_ready,  1'b0);
    chk({tag, "_sym_bit"},    sym_bit,    1'b0);
    chk({tag, "_sym_strobe"}, sym_strobe, 1'b0);
    chk({tag, "_tx_en"},      tx_en,      1'b0);
    chk({tag, "_strm_sel_q"}, strm_sel_q, 1'b0);
    chk({tag, "_busy"},       busy,       1'b0);
    chk({tag, "_done"},       done,       1'b0);
    chk({tag, "_underrun"},   underrun,   1'b0);
  endtask

  // Expected symbol bit in frame cycle c (cycle 1 = first preamble sample).
  function automatic logic exp_sym(input int c, input logic [7:0] p);
    if (c >= 1 && c <= 16)  return (((c - 1) / 4) % 2) == 0;
    if (c >= 17 && c <= 48) return p[7 - (c - 17) / 4];
    return 1'b0;
  endfunction

  // Caller has accepted start; we are in frame cycle 1. Ends in cycle last_c.
  task automatic run_frame(input logic [7:0] p, input int bad_c, input int under_from,
                           input logic strm_exp, input int last_c, input logic hold);
    for (int c = 1; c <= last_c; c++) begin
      chk($sformatf("busy@%0d", c),   busy,  (c >= 1 && c <= 56));
      chk($sformatf("tx_en@%0d", c),  tx_en, (c >= 1 && c <= 48));
      chk($sformatf("sym_bit@%0d", c), sym_bit, exp_sym(c, p));
      chk($sformatf("bit_ready@%0d", c), bit_ready, (c >= 16 && c <= 44 && c % 4 == 0));
      chk($sformatf("strobe@%0d", c), sym_strobe, (c <= 48 && (c - 1) % 4 == 0));
      chk($sformatf("done@%0d", c),   done,  (c == 57));
      chk($sformatf("underrun@%0d", c), underrun, (under_from > 0 && c >= under_from));
      chk($sformatf("strm_sel_q@%0d", c), strm_sel_q, (c <= 56) ? strm_exp : strm_sel_q);
      if (sym_strobe) n_strobe++;
      if (bit_ready)  n_ready++;
      if (c == 1) begin
        if (!hold) start = 1'b0;
        cfg_use_q = 1'b0;
      end
      bit_valid = (c != bad_c);
      if (c >= 16 && c <= 44 && c % 4 == 0) bit_in = p[7 - (c - 16) / 4];
      if (c < last_c) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_use_q = 1'b0; bit_in = 1'b0; bit_valid = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // Nominal frame, payload 1100_1010.
    n_strobe = 0; n_ready = 0;
    start = 1'b1; tick();
    run_frame(8'b1100_1010, 0, 0, 1'b0, 58, 1'b0);
    chk("strobe_count_is_12", (n_strobe == 12), 1'b1);
    chk("ready_count_is_8",   (n_ready == 8),   1'b1);

    // Underrun at cycle 24 forces payload symbol index 2 to 0.
    start = 1'b1; tick();
    run_frame(8'b1101_1111, 24, 25, 1'b0, 58, 1'b0);

    // Next accepted start clears underrun; reset hits mid-payload at cycle 30.
    start = 1'b1; tick();
    run_frame(8'b1100_1010, 0, 0, 1'b0, 30, 1'b0);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_all_zero("post_rst");

    // Clean frame after reset.
    start = 1'b1; tick();
    run_frame(8'b1100_1010, 0, 0, 1'b0, 58, 1'b0);

    // start held high, cfg_use_q=1 only at accept: back-to-back frames.
    start = 1'b1; cfg_use_q = 1'b1; tick();
    run_frame(8'b1100_1010, 0, 0, 1'b1, 57, 1'b1);
    tick();
    chk("b2b_busy@58",   busy,       1'b1);
    chk("b2b_strobe@58", sym_strobe, 1'b1);
    chk("b2b_sym@58",    sym_bit,    1'b1);
    chk("b2b_tx_en@58",  tx_en,      1'b1);
    chk("b2b_done@58",   done,       1'b0);
    chk("b2b_strm@58",   strm_sel_q, 1'b0);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psk_tx_frame_ctrl.md
# psk_tx_frame_ctrl

Frame sequencer for the PSK transmit path. It is the block ahead of the modulator and the DAC I/Q-to-PSK signal extension stage. Per frame it generates a fixed alternating preamble, then a payload pulled from a bit source over a ready/valid handshake, then a silent guard interval. It paces everything in samples-per-symbol and drives DAC enable and I/Q stream select.

## Interface
Parameters:
- SPS, 8: samples (clock cycles) per symbol; legal range ≥2.
- PRE_LEN, 16: preamble length in symbols; ≥1.
- PAY_LEN, 64: payload length in symbols; ≥1.
- GUARD_LEN, 4: guard length in symbols; ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- cfg_use_q  in  1  stream select for the frame; latched when start is accepted.
- bit_in  in  1  payload bit from the source.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block will consume a payload bit this cycle.
- sym_bit  out  1  current symbol bit to the modulator; registered.
- sym_strobe  out  1  one-cycle pulse on the first sample of each PRE/PAY symbol.
- tx_en  out  1  DAC output enable; high during PREAMBLE and PAYLOAD.
- strm_sel_q  out  1  latched cfg_use_q; 0 selects the I stream, 1 selects Q.
- busy  out  1  frame in progress (PREAMBLE, PAYLOAD or GUARD).
- done  out  1  one-cycle pulse when the frame finishes.
- underrun  out  1  sticky flag: a payload bit was missing; cleared on the next accepted start.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GUARD.
- Counters:
  - sample counter samp, 0..SPS-1, width $clog2(SPS).
  - symbol counter sym, 0..max(PRE_LEN, PAY_LEN, GUARD_LEN)-1, with matching width.
  - Both counters are zeroed on every state entry.
- Counter advance: samp wraps at SPS-1. sym increments on each samp wrap.
- State transition: when sym equals the state length minus 1 and samp equals SPS-1, the block moves to the next state.
- IDLE: start=1 moves to PREAMBLE on the next cycle, latches strm_sel_q from cfg_use_q and clears underrun. start in any other state is ignored.
- PREAMBLE: symbol k carries bit ~k[0], giving the sequence 1,0,1,0,...
- PAYLOAD bit transfer:
  - bit_ready is combinational. It is high in the last sample (samp=SPS-1) of the final preamble symbol and of each payload symbol except the last.
  - A transfer occurs when bit_ready and bit_valid are both high. sym_bit takes bit_in on the next edge, which is the first sample of the payload symbol.
  - If bit_ready=1 and bit_valid=0, sym_bit takes 0 and underrun is set. The frame continues with no stall.
- GUARD: tx_en=0, sym_bit=0, sym_strobe=0, bit_ready=0. After the last guard sample the state returns to IDLE and done pulses in that IDLE cycle.
- sym_bit holds its value for all SPS samples of a symbol.
- Reset, at any time including mid-frame: state IDLE, counters 0. All outputs are 0: bit_ready, sym_bit, sym_strobe, tx_en, strm_sel_q, busy, done, underrun.

## Timing
- start accepted at edge t means: first PREAMBLE cycle is t+1, with sym_strobe=1, tx_en=1, busy=1 and sym_bit=1.
- Frame duration is (PRE_LEN+PAY_LEN+GUARD_LEN)*SPS cycles of busy=1.
- done=1 and busy=0 in the cycle after the last guard sample. A start in that cycle is accepted, so back-to-back frames have a 1-cycle gap.
- tx_en, busy and sym_bit are registered outputs. bit_ready is decoded from registered state only, with no input-to-output combinational path.
- Exactly PAY_LEN bit_ready pulses occur per frame.

## Test plan
Test configuration: SPS=4, PRE_LEN=4, PAY_LEN=8, GUARD_LEN=2.
- Nominal frame: start at cycle 0, bit_valid tied 1, payload 8'b1100_1010.
  - busy in cycles 1–56; tx_en in cycles 1–48.
  - sym_bit = 1,0,1,0 (preamble) then 1,1,0,0,1,0,1,0, each held 4 cycles.
  - bit_ready in cycles 16, 20, …, 44 (8 pulses).
  - done in cycle 57; underrun=0.
- Underrun: bit_valid=0 only at cycle 24 → symbol 3 of the payload is 0 and underrun=1 from cycle 25 until the next accepted start.
- Start handling: start held high throughout → frames at cycles 1 and 58; starts during busy have no effect. cfg_use_q=1 at accept → strm_sel_q=1 for the whole frame.
- Reset mid-frame: rst asserted at cycle 30 → all outputs 0 immediately (asynchronous). After release, start yields a clean frame beginning with preamble bit 1.
- Strobe count: across a frame, sym_strobe pulses exactly 12 times, each aligned with samp=0. There are none during GUARD.
